glyph_renderer: RTL and testbench

- VGA text-mode scan-out engine for 640x480@60.
- Consumes the tile map in vidMemory (port B) and the glyph bitmaps in glyphMemory (port B), and produces RGB332 pixels plus sync.
- Contains the light-gun flash-frame sequencer: on request, one full frame is rendered targets-white on black, so gun sensors can detect a hit.
- Screen is 40x30 tiles of 16x16 pixels.

---
 rtl/glyph_renderer.sv | 143 ++++++++++++++
 tb/tb_glyph_renderer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_renderer.sv
// glyph_renderer: 640x480 text-mode scan-out. A 3-stage fetch pipeline (tile map ->
// glyph row -> pixel) plus a one-frame light-gun flash sequencer.
module glyph_renderer #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int COLS   = 40
) (
  input  logic        CLK,
  input  logic        CLR,
  output logic [10:0] map_addr,
  input  logic [17:0] map_dout,
  output logic [9:0]  glyph_addr,
  input  logic [17:0] glyph_dout,
  input  logic        flash_req,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        video_on,
  output logic        vblank,
  output logic        frame_start,
  output logic        flash_active
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {IDLE, ARMED, FLASH} flash_state_e;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
    logic vb;
    logic fl;
  } ctl_t;

  localparam ctl_t CTL_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, vb: 1'b0, fl: 1'b0};

  logic [9:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  flash_state_e state_q, state_d;
  ctl_t         ctl0, ctl1_q, ctl1_d, ctl2_q, ctl2_d, ctl3_q, ctl3_d;
  logic [3:0]   row1_q, row1_d, col1_q, col1_d, col2_q, col2_d;
  logic [7:0]   fg2_q, fg2_d, rgb_q, rgb_d;
  logic [15:0]  glyph_row;
  logic         h_last, v_last, frame_wrap, pix2;
  logic         unused_bits;

  assign unused_bits = ^{map_dout[17:14], glyph_dout[17:16]};

  always_comb begin
    h_last     = (hcnt_q == 10'(H_TOT - 1));
    v_last     = (vcnt_q == 10'(V_TOT - 1));
    frame_wrap = h_last && v_last;
    hcnt_d     = h_last ? '0 : hcnt_q + 10'd1;
    vcnt_d     = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
  end

  // Transitions fire on the last counter cycle so the new state covers the
  // whole counter frame starting at (0,0), keeping it aligned with frame_start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flash_req)  state_d = ARMED;
      ARMED:   if (frame_wrap) state_d = FLASH;
      FLASH:   if (frame_wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctl0     = CTL_RST;
    ctl0.vis = (hcnt_q < 10'(H_VIS)) && (vcnt_q < 10'(V_VIS));
    ctl0.hs  = !((hcnt_q >= 10'(H_VIS + H_FP)) && (hcnt_q < 10'(H_VIS + H_FP + H_SYNC)));
    ctl0.vs  = !((vcnt_q >= 10'(V_VIS + V_FP)) && (vcnt_q < 10'(V_VIS + V_FP + V_SYNC)));
    ctl0.fs  = (hcnt_q == '0) && (vcnt_q == '0);
    ctl0.vb  = (vcnt_q >= 10'(V_VIS));
    ctl0.fl  = (state_q == FLASH);
    map_addr = '0;
    if (ctl0.vis) map_addr = 11'(vcnt_q[8:4]) * 11'(COLS) + 11'(hcnt_q[9:4]);
  end

  always_comb begin
    ctl1_d     = ctl0;
    row1_d     = vcnt_q[3:0];
    col1_d     = hcnt_q[3:0];
    ctl2_d     = ctl1_q;
    col2_d     = col1_q;
    fg2_d      = map_dout[13:6];
    glyph_addr = {map_dout[5:0], row1_q};
    glyph_row  = glyph_dout[15:0];
    pix2       = glyph_row[4'd15 - col2_q];
    ctl3_d     = ctl2_q;
    rgb_d      = '0;
    if (ctl2_q.vis && pix2) rgb_d = ctl2_q.fl ? '1 : fg2_q;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      state_q <= IDLE;
      ctl1_q  <= CTL_RST;
      ctl2_q  <= CTL_RST;
      ctl3_q  <= CTL_RST;
      row1_q  <= '0;
      col1_q  <= '0;
      col2_q  <= '0;
      fg2_q   <= '0;
      rgb_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      state_q <= state_d;
      ctl1_q  <= ctl1_d;
      ctl2_q  <= ctl2_d;
      ctl3_q  <= ctl3_d;
      row1_q  <= row1_d;
      col1_q  <= col1_d;
      col2_q  <= col2_d;
      fg2_q   <= fg2_d;
      rgb_q   <= rgb_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync        = ctl3_q.hs;
  assign vsync        = ctl3_q.vs;
  assign video_on     = ctl3_q.vis;
  assign vblank       = ctl3_q.vb;
  assign frame_start  = ctl3_q.fs;
  assign flash_active = ctl3_q.fl;

endmodule

// File: tb/tb_glyph_renderer.sv
// Bench for glyph_renderer on a shrunken raster (80x38 total, 64x32 visible) so
// many frames fit in a short run; expected outputs come from screen geometry rules.
module tb_glyph_renderer;

  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 32, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int COLS  = 40;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flash_req;
  logic [10:0] map_addr;
  logic [17:0] map_dout;
  logic [9:0]  glyph_addr;
  logic [17:0] glyph_dout;
  logic        hsync, vsync, video_on, vblank, frame_start, flash_active;
  logic [2:0]  red, green;
  logic [1:0]  blue;

  logic [17:0] map_mem   [0:2047];
  logic [17:0] glyph_mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;
  int k;
  bit flash_fr [0:63];
  bit armed;
  int hs_low, vs_low, vid_cnt, last_fs;

  glyph_renderer #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .COLS(COLS)
  ) dut (
    .CLK(clk), .CLR(clr_n),
    .map_addr(map_addr), .map_dout(map_dout),
    .glyph_addr(glyph_addr), .glyph_dout(glyph_dout),
    .flash_req(flash_req),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .video_on(video_on), .vblank(vblank), .frame_start(frame_start),
    .flash_active(flash_active)
  );

  always #5 clk = ~clk;

  // Registered-read memories feeding the DUT's port-B fetches.
  always @(posedge clk) begin
    map_dout   <= map_mem[map_addr];
    glyph_dout <= glyph_mem[glyph_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic int tile(input int h, input int v);
    return (v / 16) * COLS + h / 16;
  endfunction

  function automatic logic [7:0] exp_pixel(input int h, input int v, input bit fl);
    logic [17:0] ent, row;
    ent = map_mem[tile(h, v)];
    row = glyph_mem[ent[5:0] * 16 + v % 16];
    if (!row[15 - h % 16]) return 8'h00;
    return fl ? 8'hFF : ent[13:6];
  endfunction

  task automatic rst_checks();
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_video_on", video_on, 0);
    chk("rst_vblank", vblank, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_flash_active", flash_active, 0);
  endtask

  task automatic check_cycle();
    int h, v, fr, p, ph, pv, pf, ea;
    bit vis, last;
    h  = k % H_TOT;
    v  = (k / H_TOT) % V_TOT;
    fr = (k / FRAME) % 64;
    vis = (h < H_VIS) && (v < V_VIS);
    chk("map_addr", map_addr, vis ? tile(h, v) : 0);
    chk("map_addr_bound", map_addr < 11'd1200, 1);
    if (h == 16 && v == 16) chk("lit_map_addr", map_addr, 41);
    if (k >= 1) begin
      ph = (k - 1) % H_TOT;
      pv = ((k - 1) / H_TOT) % V_TOT;
      ea = (ph < H_VIS && pv < V_VIS) ? tile(ph, pv) : 0;
      chk("glyph_addr", glyph_addr, map_mem[ea][5:0] * 16 + pv % 16);
      if (ph == 16 && pv == 16) chk("lit_glyph_addr", glyph_addr, 48);
    end
    if (k < 3) begin
      rst_checks();
    end else begin
      p  = k - 3;
      ph = p % H_TOT;
      pv = (p / H_TOT) % V_TOT;
      pf = (p / FRAME) % 64;
      vis = (ph < H_VIS) && (pv < V_VIS);
      chk("rgb", {red, green, blue}, vis ? exp_pixel(ph, pv, flash_fr[pf]) : 8'h00);
      chk("video_on", video_on, vis);
      chk("hsync", hsync, !(ph >= H_VIS + H_FP && ph < H_VIS + H_FP + H_SYNC));
      chk("vsync", vsync, !(pv >= V_VIS + V_FP && pv < V_VIS + V_FP + V_SYNC));
      chk("vblank", vblank, pv >= V_VIS);
      chk("frame_start", frame_start, ph == 0 && pv == 0);
      chk("flash_active", flash_active, flash_fr[pf]);
      if (pv == 16 && (ph == 16 || ph == 31)) begin
        if (flash_fr[pf]) chk("lit_flash_on", {red, green, blue}, 8'hFF);
        else              chk("lit_fg_on", {red, green, blue}, 8'hE0);
      end
      if (pv == 16 && ph >= 17 && ph <= 30) chk("lit_px_off", {red, green, blue}, 0);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video_on) vid_cnt++;
      if (ph == H_TOT - 1) begin
        chk("hsync_width", hs_low, 8);
        hs_low = 0;
      end
      if (ph == H_TOT - 1 && pv == V_TOT - 1) begin
        chk("vsync_cycles", vs_low, 160);
        chk("video_on_cycles", vid_cnt, 2048);
        vs_low  = 0;
        vid_cnt = 0;
      end
      if (frame_start) begin
        if (last_fs < 0) chk("first_frame_start", k, 3);
        else             chk("frame_period", k - last_fs, 3040);
        last_fs = k;
      end
    end
    // A frame flashes iff a request was accepted (not armed, not flashing) during the previous frame.
    last = (h == H_TOT - 1) && (v == V_TOT - 1);
    if (last) begin
      flash_fr[(fr + 1) % 64] = armed;
      if (armed) armed = 0;
      else if (flash_req && !flash_fr[fr]) armed = 1;
    end else if (flash_req && !armed && !flash_fr[fr]) begin
      armed = 1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        k = 0;
        armed = 0;
        foreach (flash_fr[i]) flash_fr[i] = 0;
        hs_low = 0;
        vs_low = 0;
        vid_cnt = 0;
        last_fs = -1;
        chk("rst_map_addr", map_addr, 0);
        rst_checks();
      end else begin
        check_cycle();
        k++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int target;
    clr_n = 1'b0;
    flash_req = 1'b0;
    for (int i = 0; i < 2048; i++) map_mem[i] = 18'($urandom);
    for (int i = 0; i < 1024; i++) glyph_mem[i] = 18'($urandom);
    map_mem[41]   = {4'hF, 8'hE0, 6'd3};
    glyph_mem[48] = 18'h38001;
    wait_cyc(3);
    clr_n = 1'b1;
    wait_cyc(2 * FRAME + 100);

    flash_req = 1'b1;
    wait_cyc(1);
    flash_req = 1'b0;
    wait_cyc(3 * FRAME);

    flash_req = 1'b1;
    wait_cyc(4 * FRAME);
    flash_req = 1'b0;
    wait_cyc(FRAME);

    for (int i = 0; i < 2 * FRAME; i++) begin
      flash_req = ($urandom_range(0, 999) == 0);
      wait_cyc(1);
    end
    flash_req = 1'b0;
    wait_cyc(2 * FRAME);

    // Restart, arm a flash for counter frame 1, then reset asynchronously at output line 20 of it.
    clr_n = 1'b0;
    wait_cyc(5);
    clr_n = 1'b1;
    wait_cyc(100);
    flash_req = 1'b1;
    wait_cyc(1);
    flash_req = 1'b0;
    target = FRAME + 3 + 20 * H_TOT + 10;
    wait_cyc(target - 101);
    clr_n = 1'b0;
    wait_cyc(3);
    clr_n = 1'b1;
    wait_cyc(FRAME + 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
